// File: rtl/nmi_irq_ctrl_pkg.sv
// Shared definitions for the native-memory-interface interrupt controller:
// register map, address width, source mode and bus handshake state encodings.
package nmi_irq_ctrl_pkg;

  localparam int unsigned IRQ_ADDR_W = 8;

  localparam logic [IRQ_ADDR_W-1:0] IRQ_ENABLE   = 8'h00;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_MODE     = 8'h04;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_POLARITY = 8'h08;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_PENDING  = 8'h0C;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_SWSET    = 8'h10;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_STATUS   = 8'h14;
  localparam logic [IRQ_ADDR_W-1:0] IRQ_CLAIM    = 8'h18;

  typedef enum logic {
    LEVEL = 1'b0,
    EDGE  = 1'b1
  } irq_mode_e;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  // Expand the four byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/nmi_irq_src.sv
// One interrupt source: input synchroniser, polarity, edge detect and the
// pending flop (sticky in edge mode, reloaded every cycle in level mode).
module nmi_irq_src
  import nmi_irq_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      pin,
  input  irq_mode_e mode,
  input  logic      pol,
  input  logic      swset,
  input  logic      w1c,
  output logic      pending
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_prev_q;
  logic                   edge_det;
  logic                   pending_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  assign s        = sync_q[SYNC_STAGES-1] ^ pol;
  assign edge_det = s & ~s_prev_q;

  // Set (edge or software) takes priority over a same-cycle clear.
  always_comb begin
    pending_d = pending;
    if (mode == EDGE) begin
      pending_d = edge_det | swset | (pending & ~w1c);
    end else begin
      pending_d = s | swset;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_prev_q <= 1'b0;
      pending  <= 1'b0;
    end else begin
      s_prev_q <= s;
      pending  <= pending_d;
    end
  end

endmodule

// File: rtl/nmi_irq_ctrl.sv
// Programmable interrupt controller behind a native-memory-interface slave:
// per-source enable/mode/polarity registers, pending collection and CLAIM.
module nmi_irq_ctrl
  import nmi_irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NUM_IRQ-1:0]    irq_src_i,
  input  logic                  mem_valid_i,
  input  logic [IRQ_ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  input  logic [3:0]            mem_wstrb_i,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_ready_o,
  output logic [31:0]           irq_o,
  output logic                  irq_any_o
);

  logic [NUM_IRQ-1:0] enable_q;
  logic [NUM_IRQ-1:0] mode_q;
  logic [NUM_IRQ-1:0] pol_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] swset;
  logic [NUM_IRQ-1:0] w1c;

  bus_state_e  state_q;
  bus_state_e  state_d;
  logic        access;
  logic        is_write;
  logic [5:0]  word;
  logic [31:0] bmask;
  logic [31:0] wbits;
  logic [31:0] rdata_d;
  logic        unused_addr_lsb;

  logic [31:0] en_ext;
  logic [31:0] mode_ext;
  logic [31:0] pol_ext;
  logic [31:0] pend_ext;
  logic [31:0] status_ext;
  logic [31:0] claim;

  assign word            = mem_addr_i[IRQ_ADDR_W-1:2];
  assign unused_addr_lsb = ^mem_addr_i[1:0];
  assign access          = (state_q == BUS_IDLE) && mem_valid_i;
  assign is_write        = access && (mem_wstrb_i != 4'h0);
  assign bmask           = strb_mask(mem_wstrb_i);
  assign wbits           = mem_wdata_i & bmask;

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUS_IDLE: if (mem_valid_i) state_d = BUS_ACK;
      BUS_ACK:  state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    swset = '0;
    w1c   = '0;
    if (is_write && word == IRQ_SWSET[IRQ_ADDR_W-1:2]) swset = wbits[NUM_IRQ-1:0];
    if (is_write && word == IRQ_PENDING[IRQ_ADDR_W-1:2]) w1c = wbits[NUM_IRQ-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      enable_q <= '0;
      mode_q   <= '0;
      pol_q    <= '0;
    end else if (is_write) begin
      if (word == IRQ_ENABLE[IRQ_ADDR_W-1:2])
        enable_q <= (enable_q & ~bmask[NUM_IRQ-1:0]) | wbits[NUM_IRQ-1:0];
      if (word == IRQ_MODE[IRQ_ADDR_W-1:2])
        mode_q <= (mode_q & ~bmask[NUM_IRQ-1:0]) | wbits[NUM_IRQ-1:0];
      if (word == IRQ_POLARITY[IRQ_ADDR_W-1:2])
        pol_q <= (pol_q & ~bmask[NUM_IRQ-1:0]) | wbits[NUM_IRQ-1:0];
    end
  end

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_src
    nmi_irq_src #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_src (
      .clk     (clk_i),
      .rst_n   (rst_n_i),
      .pin     (irq_src_i[g]),
      .mode    (irq_mode_e'(mode_q[g])),
      .pol     (pol_q[g]),
      .swset   (swset[g]),
      .w1c     (w1c[g]),
      .pending (pending[g])
    );
  end

  always_comb begin
    en_ext   = '0;
    mode_ext = '0;
    pol_ext  = '0;
    pend_ext = '0;
    en_ext[NUM_IRQ-1:0]   = enable_q;
    mode_ext[NUM_IRQ-1:0] = mode_q;
    pol_ext[NUM_IRQ-1:0]  = pol_q;
    pend_ext[NUM_IRQ-1:0] = pending;
  end

  assign status_ext = pend_ext & en_ext;
  assign irq_o      = status_ext;
  assign irq_any_o  = |status_ext;

  // Scan from the top so the lowest set bit is the last assignment.
  always_comb begin
    claim = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (status_ext[5'(31 - i)]) claim = 32 - i;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (word)
      IRQ_ENABLE[IRQ_ADDR_W-1:2]:   rdata_d = en_ext;
      IRQ_MODE[IRQ_ADDR_W-1:2]:     rdata_d = mode_ext;
      IRQ_POLARITY[IRQ_ADDR_W-1:2]: rdata_d = pol_ext;
      IRQ_PENDING[IRQ_ADDR_W-1:2]:  rdata_d = pend_ext;
      IRQ_STATUS[IRQ_ADDR_W-1:2]:   rdata_d = status_ext;
      IRQ_CLAIM[IRQ_ADDR_W-1:2]:    rdata_d = claim;
      default:                      rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= BUS_IDLE;
      mem_ready_o <= 1'b0;
      mem_rdata_o <= '0;
    end else begin
      state_q     <= state_d;
      mem_ready_o <= access;
      mem_rdata_o <= access ? rdata_d : '0;
    end
  end

endmodule

// File: tb/tb_nmi_irq_ctrl.sv
// Scoreboard bench for nmi_irq_ctrl: bus accesses queue their expected read
// data, a monitor pops and compares on every ready pulse.
module tb_nmi_irq_ctrl;
  import nmi_irq_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n0, rst_n12;
  logic [31:0] src0;
  logic [11:0] src12;
  logic        valid, sel;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        valid0, valid1;
  logic [31:0] rdata0, rdata1, irq0, irq1;
  logic        ready0, ready1, any0, any1;
  logic        ready_m;
  logic [31:0] rdata_m;

  assign valid0  = valid & ~sel;
  assign valid1  = valid & sel;
  assign ready_m = ready0 | ready1;
  assign rdata_m = ready1 ? rdata1 : rdata0;

  nmi_irq_ctrl u_dut (
    .clk_i(clk), .rst_n_i(rst_n0), .irq_src_i(src0),
    .mem_valid_i(valid0), .mem_addr_i(addr), .mem_wdata_i(wdata), .mem_wstrb_i(wstrb),
    .mem_rdata_o(rdata0), .mem_ready_o(ready0), .irq_o(irq0), .irq_any_o(any0)
  );

  nmi_irq_ctrl #(.NUM_IRQ(12), .SYNC_STAGES(2)) u_dut12 (
    .clk_i(clk), .rst_n_i(rst_n12), .irq_src_i(src12),
    .mem_valid_i(valid1), .mem_addr_i(addr), .mem_wdata_i(wdata), .mem_wstrb_i(wstrb),
    .mem_rdata_o(rdata1), .mem_ready_o(ready1), .irq_o(irq1), .irq_any_o(any1)
  );

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial begin : monitor
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ready_m) begin
        checks++;
        if (prev) begin
          errors++;
          $display("FAIL ready_consecutive: got ready high two cycles, expected single pulse");
        end
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready: got ready with empty scoreboard, expected none");
        end else begin
          e = exp_q.pop_front();
          if (e.chk) check(e.nm, rdata_m, e.exp);
        end
      end
      prev = ready_m;
    end
  end

  task automatic bus(input bit s, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] st, input bit chk, input logic [31:0] exp,
                     input string nm);
    exp_t e;
    int   n;
    e.chk = chk; e.exp = exp; e.nm = nm;
    exp_q.push_back(e);
    @(negedge clk);
    sel = s; addr = a; wdata = d; wstrb = st; valid = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!ready_m && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL latency_%s: got ready after %0d extra cycles, expected 0", nm, n);
      if (!ready_m) e = exp_q.pop_back();
    end
    @(negedge clk);
    valid = 1'b0; wstrb = 4'h0;
  endtask

  task automatic rd(input bit s, input logic [7:0] a, input logic [31:0] exp, input string nm);
    bus(s, a, 32'h0, 4'h0, 1'b1, exp, nm);
  endtask

  task automatic wr(input bit s, input logic [7:0] a, input logic [31:0] d, input logic [3:0] st);
    bus(s, a, d, st, 1'b0, 32'h0, "wr");
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1);
  end

  initial begin : stim
    valid = 1'b0; sel = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    src0 = '0; src12 = '0;
    rst_n0 = 1'b0; rst_n12 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_irq",   irq0, 32'h0);
    check("rst_any",   {31'h0, any0}, 32'h0);
    check("rst_ready", {31'h0, ready0}, 32'h0);
    check("rst_rdata", rdata0, 32'h0);
    check("rst_irq12", irq1, 32'h0);
    @(negedge clk);
    rst_n0 = 1'b1; rst_n12 = 1'b1;

    // Every offset reads zero after reset, including an unmapped one.
    rd(0, IRQ_ENABLE,   32'h0, "rd_enable0");
    rd(0, IRQ_MODE,     32'h0, "rd_mode0");
    rd(0, IRQ_POLARITY, 32'h0, "rd_pol0");
    rd(0, IRQ_PENDING,  32'h0, "rd_pend0");
    rd(0, IRQ_SWSET,    32'h0, "rd_swset0");
    rd(0, IRQ_STATUS,   32'h0, "rd_status0");
    rd(0, IRQ_CLAIM,    32'h0, "rd_claim0");
    rd(0, 8'h40,        32'h0, "rd_0x40");
    check("post_rst_irq", irq0, 32'h0);

    // Edge mode, source 3.
    wr(0, IRQ_MODE, 32'h8, 4'hF);
    wr(0, IRQ_ENABLE, 32'h8, 4'hF);
    @(negedge clk); src0[3] = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("edge_early", irq0, 32'h0);
    @(posedge clk); #1;
    check("edge_irq", irq0, 32'h8);
    check("edge_any", {31'h0, any0}, 32'h1);
    @(negedge clk); src0[3] = 1'b0;
    rd(0, IRQ_PENDING, 32'h8, "edge_pending");
    rd(0, IRQ_CLAIM,   32'h4, "edge_claim");
    wr(0, IRQ_PENDING, 32'h8, 4'hF);
    check("edge_w1c_irq", irq0, 32'h0);
    rd(0, IRQ_PENDING, 32'h0, "edge_pending_clr");

    // Level mode, active-low, source 0.
    wr(0, IRQ_POLARITY, 32'h1, 4'hF);
    wr(0, IRQ_ENABLE, 32'h1, 4'hF);
    check("lvl_irq", irq0, 32'h1);
    wr(0, IRQ_PENDING, 32'h1, 4'hF);
    check("lvl_w1c_noeffect", irq0, 32'h1);
    rd(0, IRQ_PENDING, 32'h1, "lvl_pending");
    @(negedge clk); src0[0] = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("lvl_hold", irq0, 32'h1);
    @(posedge clk); #1;
    check("lvl_drop", irq0, 32'h0);
    wr(0, IRQ_ENABLE, 32'h0, 4'hF);
    wr(0, IRQ_POLARITY, 32'h0, 4'hF);
    @(negedge clk); src0[0] = 1'b0;
    repeat (4) @(posedge clk);

    // Edge on source 5 lands on the same edge as its W1C.
    wr(0, IRQ_MODE, 32'h20, 4'hF);
    @(negedge clk); src0[5] = 1'b1;
    @(posedge clk); @(posedge clk);
    wr(0, IRQ_PENDING, 32'h20, 4'hF);
    rd(0, IRQ_PENDING, 32'h20, "coincident_set_wins");
    wr(0, IRQ_PENDING, 32'h20, 4'hF);
    rd(0, IRQ_PENDING, 32'h0, "w1c_after_edge");
    @(negedge clk); src0[5] = 1'b0;

    // Priority and masking.
    wr(0, IRQ_MODE, 32'h120, 4'hF);
    wr(0, IRQ_ENABLE, 32'h100, 4'hF);
    wr(0, IRQ_SWSET, 32'h120, 4'hF);
    rd(0, IRQ_STATUS,  32'h100, "prio_status");
    rd(0, IRQ_CLAIM,   32'h9,   "prio_claim9");
    rd(0, IRQ_PENDING, 32'h120, "prio_pending");
    rd(0, IRQ_SWSET,   32'h0,   "swset_reads0");
    check("prio_irq", irq0, 32'h100);
    wr(0, IRQ_ENABLE, 32'h120, 4'hF);
    rd(0, IRQ_CLAIM,  32'h6,   "prio_claim6");
    rd(0, IRQ_STATUS, 32'h120, "prio_status2");
    wr(0, IRQ_MODE, 32'h100, 4'hF);
    rd(0, IRQ_PENDING, 32'h100, "level_drops_swset");

    // NUM_IRQ=12 instance: byte strobes and width clipping.
    wr(1, IRQ_ENABLE, 32'hFFFF_FFFF, 4'h2);
    rd(1, IRQ_ENABLE, 32'h0000_0F00, "strb_enable");
    wr(1, IRQ_MODE, 32'hFFFF_FFFF, 4'hF);
    rd(1, IRQ_MODE, 32'h0000_0FFF, "clip_mode");
    wr(1, IRQ_SWSET, 32'hFFFF_FFFF, 4'hF);
    rd(1, IRQ_PENDING, 32'h0000_0FFF, "clip_pending");
    rd(1, IRQ_CLAIM,   32'h9, "n12_claim");
    check("n12_irq", irq1, 32'h0000_0F00);

    // Reset during the ACK cycle: no ready reaches the monitor.
    @(negedge clk);
    sel = 1'b1; addr = IRQ_ENABLE; wstrb = 4'h0; valid = 1'b1;
    @(posedge clk); #1;
    check("ack_before_reset", {31'h0, ready1}, 32'h1);
    rst_n12 = 1'b0;
    #1;
    check("reset_drops_ready", {31'h0, ready1}, 32'h0);
    check("reset_clears_irq", irq1, 32'h0);
    @(negedge clk);
    valid = 1'b0;
    rst_n12 = 1'b1;
    rd(1, IRQ_ENABLE,  32'h0, "rst_enable12");
    rd(1, IRQ_MODE,    32'h0, "rst_mode12");
    rd(1, IRQ_PENDING, 32'h0, "rst_pending12");

    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
        @(posedge clk);
        n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
